// File: rtl/multi_mode_reg_pipe.sv
// Core register with load / XOR / hold / clear / rotate update modes, followed by a
// delay pipeline that carries an "updated" flag per word, plus a saturating XOR counter.
module multi_mode_reg_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3,
    parameter int CNTW  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic [CNTW-1:0]  xor_cnt,
    output logic [WIDTH-1:0] core
);

    typedef enum logic [1:0] {
        MODE_XOR    = 2'b00,
        MODE_HOLD   = 2'b01,
        MODE_CLEAR  = 2'b10,
        MODE_ROTATE = 2'b11
    } mode_t;

    // stage[0] is the core register; stage[DEPTH-1] drives q, so DEPTH=1 needs no special case.
    logic [WIDTH-1:0] stage [DEPTH];
    logic [DEPTH-1:0] upd;

    // Shift-based rotate stays legal for WIDTH=1, where it degenerates to r0 itself.
    function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] v);
        return (v << 1) | (v >> (WIDTH - 1));
    endfunction

    // NOTE: all state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) stage[k] <= '0;
            upd     <= '0;
            xor_cnt <= '0;
        end else begin
            if (en) begin
                stage[0] <= d;
                upd[0]   <= 1'b1;
                xor_cnt  <= '0;
            end else begin
                case (mode_t'(mode))
                    MODE_XOR: begin
                        stage[0] <= stage[0] ^ d;
                        upd[0]   <= 1'b1;
                        if (xor_cnt != '1) xor_cnt <= xor_cnt + CNTW'(1);
                    end
                    MODE_HOLD: begin
                        upd[0] <= 1'b0;
                    end
                    MODE_CLEAR: begin
                        stage[0] <= '0;
                        upd[0]   <= 1'b1;
                        xor_cnt  <= '0;
                    end
                    MODE_ROTATE: begin
                        stage[0] <= rotl(stage[0]);
                        upd[0]   <= 1'b1;
                    end
                    default: upd[0] <= 1'b0;
                endcase
            end
            for (int k = 1; k < DEPTH; k++) begin
                stage[k] <= stage[k-1];
                upd[k]   <= upd[k-1];
            end
        end
    end

    assign core    = stage[0];
    assign q       = stage[DEPTH-1];
    assign q_valid = upd[DEPTH-1];

endmodule
